rx_oversampler: RTL and testbench

Multi-channel successor to the single-bit synchroniser/sampler on the RFID receive path. Each asynchronous input passes through a parametrisable synchroniser chain. The synchronised value is sampled on a programmable-period strobe, and OVS consecutive samples are majority-voted into one output bit per channel. The block outputs a per-channel edge flag and one shared valid pulse, and feeds the downstream decoder.

---
 rtl/rx_oversampler.sv | 69 ++++++
 tb/tb_rx_oversampler.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/rx_oversampler.sv
// rx_oversampler: synchronises CH async inputs, samples them on a programmable strobe
// and majority-votes OVS samples into one output bit per channel.
module rx_oversampler #(
  parameter int CH      = 1,
  parameter int SYNC    = 2,
  parameter int DIV_W   = 8,
  parameter int DIV_RST = 10,
  parameter int OVS     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    rx_in,
  input  logic [DIV_W-1:0] div_cfg,
  input  logic             cfg_load,
  output logic             sample_strb,
  output logic [CH-1:0]    out_dat,
  output logic [CH-1:0]    out_edge,
  output logic             out_vld
);
  localparam int OW = $clog2(OVS + 1);
  localparam int SW = OVS > 1 ? $clog2(OVS) : 1;
  logic [CH-1:0]    sync_q [SYNC];
  logic [CH-1:0]    s;
  logic [DIV_W-1:0] period_q, period_d, cnt_q, cnt_d;
  logic [SW-1:0]    sub_q, sub_d;
  logic [OW-1:0]    ones_q [CH];
  logic [OW-1:0]    ones_d [CH];
  logic [OW-1:0]    sum    [CH];
  logic [CH-1:0]    dat_d;
  logic             close;
  assign s           = sync_q[SYNC-1];
  assign sample_strb = cnt_q == period_q - DIV_W'(1);
  assign close       = sample_strb && sub_q == SW'(OVS - 1);
  assign period_d    = cfg_load ? (div_cfg == '0 ? DIV_W'(1) : div_cfg) : period_q;
  assign cnt_d       = cfg_load || sample_strb ? '0 : cnt_q + DIV_W'(1);
  assign sub_d       = cfg_load || close ? '0 : sample_strb ? sub_q + SW'(1) : sub_q;
  // sum includes the sample taken on this edge, so the vote sees the full window
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      sum[i]    = ones_q[i] + OW'(s[i]);
      dat_d[i]  = sum[i] > OW'(OVS / 2);
      ones_d[i] = cfg_load || close ? '0 : sample_strb ? sum[i] : ones_q[i];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < SYNC; n++) sync_q[n] <= '0;
      period_q <= DIV_W'(DIV_RST);
      cnt_q    <= '0;
      sub_q    <= '0;
      ones_q   <= '{default: '0};
      out_dat  <= '0;
      out_edge <= '0;
      out_vld  <= 1'b0;
    end else begin
      sync_q[0] <= rx_in;
      for (int n = 1; n < SYNC; n++) sync_q[n] <= sync_q[n-1];
      period_q <= period_d;
      cnt_q    <= cnt_d;
      sub_q    <= sub_d;
      ones_q   <= ones_d;
      out_vld  <= close;
      if (close) begin
        out_dat  <= dat_d;
        out_edge <= dat_d ^ out_dat;
      end
    end
  end
endmodule

// File: tb/tb_rx_oversampler.sv
// tb_rx_oversampler: directed scenarios on a CH=2/OVS=3 instance checked every cycle
// against a sample-queue model, plus an OVS=1/SYNC=3 instance checked by hand.
module tb_rx_oversampler;
  localparam int A_SYNC = 2, A_OVS = 3, A_RST = 10;
  logic       clk = 0;
  logic       rst = 1, rst_b = 1;
  logic [1:0] rx_in = '0;
  logic [7:0] div_cfg = '0;
  logic       cfg_load = 0;
  logic       sample_strb, out_vld;
  logic [1:0] out_dat, out_edge;
  logic [0:0] rx_b = '0, dat_b, edge_b;
  logic       strb_b, vld_b;
  int         tests = 0, fails = 0, kc = 0, kb = 0;
  logic       chk_en = 0;

  rx_oversampler #(.CH(2), .SYNC(A_SYNC), .DIV_W(8), .DIV_RST(A_RST), .OVS(A_OVS)) u_dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .div_cfg(div_cfg), .cfg_load(cfg_load),
    .sample_strb(sample_strb), .out_dat(out_dat), .out_edge(out_edge), .out_vld(out_vld));

  rx_oversampler #(.CH(1), .SYNC(3), .DIV_W(8), .DIV_RST(5), .OVS(1)) u_dut1 (
    .clk(clk), .rst(rst_b), .rx_in(rx_b), .div_cfg(8'd0), .cfg_load(1'b0),
    .sample_strb(strb_b), .out_dat(dat_b), .out_edge(edge_b), .out_vld(vld_b));

  always #5 clk = ~clk;

  // Model: strobe every period cycles from the last reset/load edge; s lags rx_in by SYNC edges
  int         mk, mper;
  logic [1:0] hist[$], win[$];
  logic [1:0] m_dat, m_edge;
  logic       m_vld, m_strb;
  assign m_strb = (mk + 1) % mper == 0;

  task automatic model_step();
    logic [1:0] sv, nd;
    int ones;
    if (rst) begin
      mk = 0; mper = A_RST; hist = {}; win = {};
      for (int i = 0; i < A_SYNC; i++) hist.push_back(2'b00);
      m_dat = '0; m_edge = '0; m_vld = 0;
    end else begin
      sv = hist.pop_front();
      hist.push_back(rx_in);
      m_vld = 0;
      if ((mk + 1) % mper == 0) begin
        win.push_back(sv);
        if (win.size() == A_OVS) begin
          for (int c = 0; c < 2; c++) begin
            ones = 0;
            foreach (win[j]) ones += int'(win[j][c]);
            nd[c] = ones > A_OVS / 2;
          end
          m_edge = nd ^ m_dat; m_dat = nd; m_vld = 1; win = {};
        end
      end
      if (cfg_load) begin
        mper = div_cfg == 0 ? 1 : int'(div_cfg); mk = 0; win = {};
      end else mk++;
    end
  endtask

  initial forever begin @(posedge clk); model_step(); end
  initial forever begin @(posedge clk); kc = rst ? 0 : kc + 1; end
  initial forever begin @(posedge clk); kb = rst_b ? 0 : kb + 1; end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s (k=%0d): got %0h expected %0h", n, kc, a, e);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("cmp_strb", sample_strb, m_strb);
      chk("cmp_vld", out_vld, m_vld);
      chk("cmp_dat", out_dat, m_dat);
      if (m_vld) chk("cmp_edge", out_edge, m_edge);
    end
  end

  task automatic goto(input int k);
    int g = 0;
    do begin @(negedge clk); g++; end while (kc < k - 1 && g < 1000);
    if (kc != k - 1) begin tests++; fails++; $display("FAIL goto %0d: reached %0d", k, kc + 1); end
  endtask

  task automatic gotob(input int k);
    int g = 0;
    do begin @(negedge clk); g++; end while (kb < k - 1 && g < 1000);
    if (kb != k - 1) begin tests++; fails++; $display("FAIL gotob %0d: reached %0d", k, kb + 1); end
  endtask

  task automatic do_reset(input logic [1:0] rx);
    rx_in = rx; cfg_load = 0; div_cfg = '0; rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_dat", out_dat, 2'b00);
    chk("rst_edge", out_edge, 2'b00);
    chk("rst_vld", out_vld, 1'b0);
    chk("rst_strb", sample_strb, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // steady input
    do_reset(2'b01);
    chk_en = 1;
    goto(10); chk("s1_strb10", sample_strb, 1);
    goto(20); chk("s1_strb20", sample_strb, 1);
    goto(30); chk("s1_strb30", sample_strb, 1); chk("s1_vld30", out_vld, 0);
    goto(31); chk("s1_vld31", out_vld, 1); chk("s1_dat31", out_dat, 2'b01);
    chk("s1_edge31", out_edge, 2'b01); chk("s1_model31", m_dat, 2'b01);
    goto(61); chk("s1_vld61", out_vld, 1); chk("s1_edge61", out_edge, 2'b00);
    goto(91); chk("s1_vld91", out_vld, 1); chk("s1_model91", m_vld, 1);
    // ch0 high for one sample only, ch1 high for two of three
    do_reset(2'b00);
    goto(18); rx_in = 2'b11;
    goto(19); rx_in = 2'b10;
    goto(29); rx_in = 2'b00;
    goto(31); chk("s2_vld31", out_vld, 1); chk("s2_dat31", out_dat, 2'b10);
    chk("s2_edge31", out_edge, 2'b10);
    // reconfiguration mid-window, then period 0 -> 1
    do_reset(2'b01);
    goto(15); cfg_load = 1; div_cfg = 8'd4;
    goto(16); cfg_load = 0;
    goto(19); chk("s3_strb19", sample_strb, 1);
    goto(23); chk("s3_strb23", sample_strb, 1);
    goto(27); chk("s3_strb27", sample_strb, 1);
    goto(28); chk("s3_vld28", out_vld, 1); chk("s3_dat28", out_dat, 2'b01);
    chk("s3_edge28", out_edge, 2'b01);
    goto(31); chk("s3_vld31", out_vld, 0);
    goto(45); cfg_load = 1; div_cfg = 8'd0;
    goto(46); cfg_load = 0; chk("s3_strb46", sample_strb, 1);
    goto(47); chk("s3_strb47", sample_strb, 1);
    goto(49); chk("s3_vld49", out_vld, 1); chk("s3_edge49", out_edge, 2'b00);
    // cfg_load on the closing edge
    do_reset(2'b01);
    goto(30); cfg_load = 1; div_cfg = 8'd6; chk("s4_strb30", sample_strb, 1);
    goto(31); cfg_load = 0; chk("s4_vld31", out_vld, 1); chk("s4_dat31", out_dat, 2'b01);
    goto(35); chk("s4_strb35", sample_strb, 0);
    goto(36); chk("s4_strb36", sample_strb, 1);
    goto(49); chk("s4_vld49", out_vld, 1);
    // reset mid-window with out_dat already high
    do_reset(2'b01);
    goto(55); chk("s5_dat55", out_dat, 2'b01);
    do_reset(2'b01);
    goto(10); chk("s5_strb10", sample_strb, 1);
    goto(30); chk("s5_vld30", out_vld, 0); chk("s5_dat30", out_dat, 2'b00);
    goto(31); chk("s5_vld31", out_vld, 1); chk("s5_edge31", out_edge, 2'b01);
    // OVS=1, SYNC=3, period 5 instance
    chk_en = 0;
    repeat (2) @(posedge clk);
    chk("b_rst_vld", vld_b, 0); chk("b_rst_dat", dat_b, 0);
    #1 rst_b = 0;
    for (int k = 1; k <= 16; k++) begin
      gotob(k);
      if (k == 7) rx_b = 1'b1;
      chk($sformatf("b_strb%0d", k), strb_b, k % 5 == 0);
      chk($sformatf("b_vld%0d", k), vld_b, k % 5 == 1 && k > 1);
      chk($sformatf("b_dat%0d", k), dat_b, k >= 11);
      if (k == 6 || k == 11 || k == 16) chk($sformatf("b_edge%0d", k), edge_b, k == 11);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
